// File: rtl/fsab_rr_arbiter.sv
// fsab_rr_arbiter: credit-based arbiter sharing the FSAB request channel among FSAB_DEVICES masters
// Define FSAB_ARB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module fsab_rr_arbiter #(
    parameter int FSAB_DEVICES = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int DS_CREDITS = 4,
    parameter int MODE_W = 1,
    parameter int DID_W = 4,
    parameter int SUBDID_W = 4,
    parameter int ADDR_W = 31,
    parameter int LEN_W = 4,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8,
    parameter logic [MODE_W-1:0] FSAB_WRITE = MODE_W'(1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FSAB_DEVICES-1:0]            fsabo_valids,
    input  logic [FSAB_DEVICES*MODE_W-1:0]     fsabo_modes,
    input  logic [FSAB_DEVICES*DID_W-1:0]      fsabo_dids,
    input  logic [FSAB_DEVICES*SUBDID_W-1:0]   fsabo_subdids,
    input  logic [FSAB_DEVICES*ADDR_W-1:0]     fsabo_addrs,
    input  logic [FSAB_DEVICES*LEN_W-1:0]      fsabo_lens,
    input  logic [FSAB_DEVICES*DATA_W-1:0]     fsabo_datas,
    input  logic [FSAB_DEVICES*MASK_W-1:0]     fsabo_masks,
    output logic [FSAB_DEVICES-1:0]            fsabo_credits,
    output logic                               fsabo_valid,
    output logic [MODE_W-1:0]                  fsabo_mode,
    output logic [DID_W-1:0]                   fsabo_did,
    output logic [SUBDID_W-1:0]                fsabo_subdid,
    output logic [ADDR_W-1:0]                  fsabo_addr,
    output logic [LEN_W-1:0]                   fsabo_len,
    output logic [DATA_W-1:0]                  fsabo_data,
    output logic [MASK_W-1:0]                  fsabo_mask,
    input  logic                               fsabo_credit,
    output logic                               proto_err
);
    localparam int N = FSAB_DEVICES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DS_CREDITS + 1);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    typedef struct packed {
        logic [MODE_W-1:0]   mode;
        logic [DID_W-1:0]    did;
        logic [SUBDID_W-1:0] subdid;
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
        logic [DATA_W-1:0]   data;
        logic [MASK_W-1:0]   mask;
    } beat_t;

    // beats that follow a header; len 0 counts as a one-beat write
    function automatic logic [LEN_W-1:0] tail_beats(beat_t b);
        return (b.mode == FSAB_WRITE && b.len > LEN_W'(1)) ? b.len - 1'b1 : '0;
    endfunction

    logic [N-1:0] empty, full, push, pop, head_hdr, elig;
    beat_t head_beat [N];
    logic [0:0] state;
    logic [PW-1:0] sel, gnt, pop_idx;
    logic [LEN_W-1:0] left;
    logic [CW-1:0] ds_cnt;
    logic found, go, last, ds_ovf;
    beat_t pb;

    // header tagging happens at ingress, tracking each device's packet boundaries
    for (genvar i = 0; i < N; i++) begin : g_dev
        beat_t mem [FIFO_DEPTH];
        logic [FIFO_DEPTH-1:0] hdr_mem;
        logic [AW:0] wp, rp;
        logic [LEN_W-1:0] in_left;
        beat_t in_beat;
        assign in_beat = '{mode: fsabo_modes[i*MODE_W +: MODE_W],
                           did: fsabo_dids[i*DID_W +: DID_W],
                           subdid: fsabo_subdids[i*SUBDID_W +: SUBDID_W],
                           addr: fsabo_addrs[i*ADDR_W +: ADDR_W],
                           len: fsabo_lens[i*LEN_W +: LEN_W],
                           data: fsabo_datas[i*DATA_W +: DATA_W],
                           mask: fsabo_masks[i*MASK_W +: MASK_W]};
        assign empty[i] = wp == rp;
        assign full[i] = (wp ^ rp) == {1'b1, {AW{1'b0}}};
        assign push[i] = fsabo_valids[i] && (!full[i] || pop[i]);
        assign head_beat[i] = mem[rp[AW-1:0]];
        assign head_hdr[i] = hdr_mem[rp[AW-1:0]];
        always_ff @(posedge clk) begin
            if (rst) begin
                wp <= '0;
                rp <= '0;
                in_left <= '0;
            end else begin
                if (push[i]) begin
                    mem[wp[AW-1:0]] <= in_beat;
                    hdr_mem[wp[AW-1:0]] <= in_left == '0;
                    in_left <= in_left == '0 ? tail_beats(in_beat) : in_left - 1'b1;
                    wp <= wp + 1'b1;
                end
                if (pop[i]) rp <= rp + 1'b1;
            end
        end
    end

    assign elig = ~empty & head_hdr;

`ifdef FSAB_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) if (elig[k]) begin
            sel = PW'(k);
            found = 1'b1;
        end
    end
`else
    logic [PW-1:0] ptr, idx;
    // scanning downward leaves the candidate nearest the pointer as the winner
    always_comb begin
        sel = '0;
        idx = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (elig[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (go && last) ptr <= pop_idx == PW'(N - 1) ? '0 : pop_idx + 1'b1;
    end
`endif

    always_comb begin
        pop_idx = state == IDLE ? sel : gnt;
        go = ds_cnt != '0 && (state == IDLE ? found : !empty[gnt]);
        pb = head_beat[pop_idx];
        last = state == IDLE ? tail_beats(pb) == '0 : left == LEN_W'(1);
        pop = go ? N'(1) << pop_idx : '0;
        ds_ovf = fsabo_credit && ds_cnt == CW'(DS_CREDITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            left <= '0;
            ds_cnt <= CW'(DS_CREDITS);
            fsabo_valid <= 1'b0;
            {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask} <= '0;
            fsabo_credits <= '0;
            proto_err <= 1'b0;
        end else begin
            fsabo_valid <= go;
            fsabo_credits <= pop;
            ds_cnt <= ds_cnt - CW'(go) + CW'(fsabo_credit && !ds_ovf);
            proto_err <= proto_err || ds_ovf || |(fsabo_valids & full & ~pop);
            if (go) begin
                {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask} <= pb;
                gnt <= pop_idx;
                left <= state == IDLE ? tail_beats(pb) : left - 1'b1;
                state <= last ? IDLE : BURST;
            end
        end
    end
endmodule

// File: tb/tb_fsab_rr_arbiter.sv
// tb_fsab_rr_arbiter: directed vectors and corner-case sequences for fsab_rr_arbiter
module tb_fsab_rr_arbiter;
    logic clk, rst, cr;
    logic [2:0] v, md, credits;
    logic [3:0] ln [3];
    logic [30:0] ad [3];
    logic [11:0] lens, dids, subdids;
    logic [92:0] addrs;
    logic [191:0] datas;
    logic [23:0] masks;
    logic valid, mode, err;
    logic [3:0] did, subdid, len;
    logic [30:0] addr;
    logic [63:0] data;
    logic [7:0] mask;
    int checks = 0, errors = 0;

    assign lens = {ln[2], ln[1], ln[0]};
    assign addrs = {ad[2], ad[1], ad[0]};
    assign dids = {4'd3, 4'd2, 4'd1};
    assign subdids = '0;
    assign datas = {{33'b0, ad[2]}, {33'b0, ad[1]}, {33'b0, ad[0]}};
    assign masks = '1;

    fsab_rr_arbiter dut (
        .clk(clk), .rst(rst),
        .fsabo_valids(v), .fsabo_modes(md), .fsabo_dids(dids), .fsabo_subdids(subdids),
        .fsabo_addrs(addrs), .fsabo_lens(lens), .fsabo_datas(datas), .fsabo_masks(masks),
        .fsabo_credits(credits), .fsabo_valid(valid), .fsabo_mode(mode), .fsabo_did(did),
        .fsabo_subdid(subdid), .fsabo_addr(addr), .fsabo_len(len), .fsabo_data(data),
        .fsabo_mask(mask), .fsabo_credit(cr), .proto_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] v;
        logic [2:0] wr;
        logic [3:0] len;
        logic [7:0] a0, a1;
        logic cr;
        logic ev;
        logic [7:0] ea;
        logic [3:0] edid;
        logic [2:0] ec;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        v = '0;
        md = '0;
        cr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ln[i] = '0;
            ad[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int cnt;
    logic prev_valid;
    logic [3:0] got [6];
    logic [3:0] exp_order [6];

    initial begin
        tbl[0] = '{v:3'b010, wr:3'b010, len:4, a0:8'h00, a1:8'h10, cr:0, ev:0, ea:8'h00, edid:0, ec:3'b000};
        tbl[1] = '{v:3'b011, wr:3'b010, len:4, a0:8'h20, a1:8'h11, cr:0, ev:0, ea:8'h00, edid:0, ec:3'b000};
        tbl[2] = '{v:3'b010, wr:3'b010, len:4, a0:8'h00, a1:8'h12, cr:1, ev:1, ea:8'h10, edid:2, ec:3'b010};
        tbl[3] = '{v:3'b010, wr:3'b010, len:4, a0:8'h00, a1:8'h13, cr:1, ev:1, ea:8'h11, edid:2, ec:3'b010};
        tbl[4] = '{v:3'b000, wr:3'b000, len:0, a0:8'h00, a1:8'h00, cr:0, ev:1, ea:8'h12, edid:2, ec:3'b010};
        tbl[5] = '{v:3'b000, wr:3'b000, len:0, a0:8'h00, a1:8'h00, cr:0, ev:1, ea:8'h13, edid:2, ec:3'b010};
        tbl[6] = '{v:3'b000, wr:3'b000, len:0, a0:8'h00, a1:8'h00, cr:0, ev:1, ea:8'h20, edid:1, ec:3'b001};
        tbl[7] = '{v:3'b000, wr:3'b000, len:0, a0:8'h00, a1:8'h00, cr:0, ev:0, ea:8'h00, edid:0, ec:3'b000};
`ifdef FSAB_ARB_FIXED_PRIO_EN
        exp_order = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1};
`else
        exp_order = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
`endif

        do_reset();
        check("reset valid", valid, 0);
        check("reset credits", credits, 0);
        check("reset err", err, 0);
        check("reset addr", addr, 0);
        check("reset data", data, 0);
        check("reset did", did, 0);

        // burst atomicity with a competing read
        for (int r = 0; r < 8; r++) begin
            next_cycle();
            v = tbl[r].v;
            md = tbl[r].wr;
            cr = tbl[r].cr;
            ln[0] = '0;
            ln[1] = tbl[r].len;
            ad[0] = {23'b0, tbl[r].a0};
            ad[1] = {23'b0, tbl[r].a1};
            @(negedge clk);
            check($sformatf("row%0d valid", r), valid, tbl[r].ev);
            check($sformatf("row%0d credits", r), credits, tbl[r].ec);
            check($sformatf("row%0d err", r), err, 0);
            if (tbl[r].ev) begin
                check($sformatf("row%0d addr", r), addr, {23'b0, tbl[r].ea});
                check($sformatf("row%0d did", r), did, tbl[r].edid);
                check($sformatf("row%0d data", r), data, {56'b0, tbl[r].ea});
            end
        end

        // arbitration order with all devices queued and credits returned
        do_reset();
        cnt = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            v = c < 2 ? 3'b111 : 3'b000;
            md = '0;
            cr = prev_valid;
            for (int i = 0; i < 3; i++) ad[i] = 31'(i * 16 + c);
            @(negedge clk);
            if (valid && cnt < 6) got[cnt] = did;
            if (valid) cnt++;
            prev_valid = valid;
        end
        check("order count", cnt, 6);
        for (int k = 0; k < 6; k++) check($sformatf("order%0d", k), got[k], exp_order[k]);
        check("order err", err, 0);

        // credit starvation then a single returned credit
        do_reset();
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            v = {1'b0, c < 2, c < 4};
            @(negedge clk);
            if (valid) cnt++;
        end
        check("starve count", cnt, 4);
        next_cycle();
        v = '0;
        cr = 1'b1;
        @(negedge clk);
        check("starve credit+0", valid, 0);
        next_cycle();
        cr = 1'b0;
        @(negedge clk);
        check("starve credit+1", valid, 0);
        next_cycle();
        @(negedge clk);
        check("starve credit+2", valid, 1);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            if (valid) cnt++;
        end
        check("starve extra", cnt, 0);

        // ingress overflow drops the fifth beat
        do_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            v = {1'b0, c < 4, 1'b0};
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            v = 3'b100;
            ad[2] = 31'(c);
            @(negedge clk);
            check($sformatf("fill%0d err", c), err, 0);
        end
        next_cycle();
        v = '0;
        @(negedge clk);
        check("overflow err", err, 1);
        cnt = 0;
        for (int c = 0; c < 11; c++) begin
            next_cycle();
            cr = c < 5;
            @(negedge clk);
            if (valid) cnt++;
        end
        check("overflow drained", cnt, 4);

        // downstream credit overflow keeps the counter saturated
        do_reset();
        next_cycle();
        cr = 1'b1;
        @(negedge clk);
        check("cr ovf err before", err, 0);
        next_cycle();
        cr = 1'b0;
        @(negedge clk);
        check("cr ovf err", err, 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            v = {1'b0, c < 3, c < 3};
            @(negedge clk);
            if (valid) cnt++;
        end
        check("cr ovf beats", cnt, 4);

        // reset in the middle of a write burst
        do_reset();
        next_cycle();
        v = 3'b010;
        md = 3'b010;
        ln[1] = 4'd4;
        ad[1] = 31'h40;
        @(negedge clk);
        next_cycle();
        ad[1] = 31'h41;
        @(negedge clk);
        next_cycle();
        ad[1] = 31'h42;
        @(negedge clk);
        check("mid beat1 valid", valid, 1);
        check("mid beat1 addr", addr, 31'h40);
        next_cycle();
        v = '0;
        rst = 1'b1;
        @(negedge clk);
        check("mid beat2 addr", addr, 31'h41);
        check("mid beat2 credits", credits, 3'b010);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("mid reset valid", valid, 0);
        check("mid reset credits", credits, 0);
        check("mid reset err", err, 0);
        cnt = 0;
        md = '0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            v = {2'b00, k < 6};
            ad[0] = 31'(8'h50 + k);
            @(negedge clk);
            if (k == 1) check("post reset early", valid, 0);
            if (k == 2) begin
                check("post reset valid", valid, 1);
                check("post reset addr", addr, 31'h50);
                check("post reset credits", credits, 3'b001);
            end
            if (valid) cnt++;
        end
        check("post reset beats", cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
